fetch_buffer: RTL and testbench

- Consumer end of the PC-generator interface. Takes each fetch address from the PC update block and issues it to instruction memory.
- Receives the in-order instruction responses and buffers each {pc, instruction} pair in a small ring.
- Delivers pairs to decode with a valid/ready handshake.
- Supports a single-cycle flush on a taken branch: discards buffered entries and drops responses for requests that are still in flight.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_buffer_if.sv | 42 ++++
 rtl/fetch_ring.sv | 90 +++++++++
 rtl/fetch_buffer.sv | 89 ++++++++
 tb/tb_fetch_buffer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ======================================================================
// fetch_pkg : shared widths, ring entry type and pointer-width helper
// Revision  : 1.0
// ======================================================================
package fetch_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 64;
  localparam int unsigned INSTR_W_DEFAULT = 32;

  // Entry fields are sized at the default widths.
  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0]  pc;
    logic [INSTR_W_DEFAULT-1:0] instr;
    logic                       filled;
  } fetch_entry_t;

  // Ring index plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_if.sv
`default_nettype none
// ======================================================================
// fetch_buffer_if : PC, instruction-memory and decode handshake bundle
// Revision        : 1.0
// ======================================================================
interface fetch_buffer_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT
);

  logic [ADDR_W-1:0]  pc_in;
  logic               pc_valid;
  logic               pc_ready;
  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               dec_valid;
  logic [ADDR_W-1:0]  dec_pc;
  logic [INSTR_W-1:0] dec_instr;
  logic               dec_ready;
  logic               flush;

  modport slave (
    input  pc_in, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           dec_ready, flush,
    output pc_ready, imem_req_valid, imem_req_addr, dec_valid, dec_pc,
           dec_instr
  );

  modport master (
    output pc_in, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           dec_ready, flush,
    input  pc_ready, imem_req_valid, imem_req_addr, dec_valid, dec_pc,
           dec_instr
  );

endinterface
`default_nettype wire

// File: rtl/fetch_ring.sv
`default_nettype none
// ======================================================================
// fetch_ring : {pc, instr} ring with head/fill/tail pointers and filled bits
// Revision   : 1.0
// ======================================================================
module fetch_ring
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
  localparam int unsigned PTR_W  = ptr_w(DEPTH)
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               flush,
  input  wire logic               push,
  input  wire logic [ADDR_W-1:0]  push_pc,
  input  wire logic               fill_en,
  input  wire logic [INSTR_W-1:0] fill_instr,
  input  wire logic               pop,
  output logic      [PTR_W-1:0]   used,
  output logic      [PTR_W-1:0]   outstanding,
  output fetch_entry_t            head_entry
);

  localparam int unsigned IDX_W = PTR_W - 1;

  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   fill_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [DEPTH-1:0]   filled;
  logic [DEPTH-1:0]   filled_nxt;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] fill_idx;
  logic [IDX_W-1:0] tail_idx;

  assign head_idx    = head_ptr[IDX_W-1:0];
  assign fill_idx    = fill_ptr[IDX_W-1:0];
  assign tail_idx    = tail_ptr[IDX_W-1:0];
  assign used        = tail_ptr - head_ptr;
  assign outstanding = tail_ptr - fill_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      fill_ptr <= '0;
      tail_ptr <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      fill_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (push)    tail_ptr <= tail_ptr + PTR_W'(1);
      if (fill_en) fill_ptr <= fill_ptr + PTR_W'(1);
      if (pop)     head_ptr <= head_ptr + PTR_W'(1);
    end
  end

  // The three indices never collide on a live update: push needs space,
  // fill needs an outstanding slot, pop needs a filled head.
  always_comb begin
    filled_nxt = filled;
    if (push)    filled_nxt[tail_idx] = 1'b0;
    if (fill_en) filled_nxt[fill_idx] = 1'b1;
    if (pop)     filled_nxt[head_idx] = 1'b0;
    if (flush)   filled_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) filled <= '0;
    else        filled <= filled_nxt;
  end

  always_ff @(posedge clk) begin
    if (push && !flush)    pc_mem[tail_idx]    <= push_pc;
    if (fill_en && !flush) instr_mem[fill_idx] <= fill_instr;
  end

  always_comb begin
    head_entry.pc     = ADDR_W_DEFAULT'(pc_mem[head_idx]);
    head_entry.instr  = INSTR_W_DEFAULT'(instr_mem[head_idx]);
    head_entry.filled = filled[head_idx];
  end

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ======================================================================
// fetch_buffer : issues PCs to imem, buffers in-order responses for decode
// Revision     : 1.0
// ======================================================================
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT
) (
  input  wire logic  clk,
  input  wire logic  reset,
  fetch_buffer_if.slave bus,
  output logic       err
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned DW    = $clog2(DEPTH) + 2;

  logic [PTR_W-1:0] used;
  logic [PTR_W-1:0] outstanding;
  fetch_entry_t     head_entry;
  logic [DW-1:0]    drop_cnt;
  logic             space;
  logic             issue;
  logic             pop;
  logic             drop_active;
  logic             rsp_drop;
  logic             rsp_take;
  logic             rsp_stray;

  assign space = ({1'b0, used} < (PTR_W + 1)'(DEPTH));

  // Gating with reset keeps both handshakes quiet while reset is held.
  assign bus.imem_req_valid = reset && bus.pc_valid && space && !bus.flush;
  assign bus.pc_ready       = reset && bus.imem_req_ready && space && !bus.flush;
  assign bus.imem_req_addr  = bus.pc_in;

  assign issue = bus.pc_valid && bus.pc_ready;
  assign pop   = bus.dec_valid && bus.dec_ready;

  assign drop_active = (drop_cnt != '0);
  assign rsp_drop    = bus.imem_rsp_valid && drop_active;
  assign rsp_take    = bus.imem_rsp_valid && !drop_active && (outstanding != '0);
  assign rsp_stray   = bus.imem_rsp_valid && !drop_active && (outstanding == '0);

  assign bus.dec_valid = head_entry.filled;
  assign bus.dec_pc    = ADDR_W'(head_entry.pc);
  assign bus.dec_instr = INSTR_W'(head_entry.instr);

  fetch_ring #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ring (
    .clk         (clk),
    .reset       (reset),
    .flush       (bus.flush),
    .push        (issue),
    .push_pc     (bus.pc_in),
    .fill_en     (rsp_take),
    .fill_instr  (bus.imem_rsp_data),
    .pop         (pop),
    .used        (used),
    .outstanding (outstanding),
    .head_entry  (head_entry)
  );

  // On flush every in-flight response becomes a drop, less any response
  // consumed in the flush cycle itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (bus.flush) begin
      drop_cnt <= drop_cnt + DW'(outstanding) - DW'(rsp_drop) - DW'(rsp_take);
    end else if (rsp_drop) begin
      drop_cnt <= drop_cnt - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         err <= 1'b0;
    else if (rsp_stray) err <= 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ======================================================================
// tb_fetch_buffer : directed scenarios for fetch_buffer
// Revision        : 1.0
// ======================================================================
module tb_fetch_buffer;

  logic clk;
  logic reset;
  logic err;
  int   vectors;
  int   miscompares;

  fetch_buffer_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

  fetch_buffer #(.DEPTH(4), .ADDR_W(64), .INSTR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    bus.pc_valid       = 1'b0;
    bus.pc_in          = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.dec_ready      = 1'b0;
    bus.flush          = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    bus.pc_valid = 1'b1;
    step();
    #1;
    vectors++; if (bus.dec_valid !== 1'b0) begin miscompares++; $display("FAIL rst_dec_valid: got %b want 0", bus.dec_valid); end
    vectors++; if (bus.pc_ready !== 1'b0) begin miscompares++; $display("FAIL rst_pc_ready: got %b want 0", bus.pc_ready); end
    vectors++; if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
    step();
    idle();
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    bus.dec_ready = 1'b1;
    bus.pc_valid = 1'b1; bus.pc_in = 64'h0; #1;
    vectors++; if (bus.pc_ready !== 1'b1) begin miscompares++; $display("FAIL basic_pc_ready: got %b want 1", bus.pc_ready); end
    vectors++; if (bus.imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL basic_req_valid: got %b want 1", bus.imem_req_valid); end
    step();
    bus.pc_in = 64'h4; #1;
    vectors++; if (bus.imem_req_addr !== 64'h4) begin miscompares++; $display("FAIL basic_req_addr: got %h want 4", bus.imem_req_addr); end
    step();
    bus.pc_in = 64'h8; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hAAAA0001; #1;
    vectors++; if (bus.dec_valid !== 1'b0) begin miscompares++; $display("FAIL basic_no_bypass: dec_valid got %b want 0", bus.dec_valid); end
    step();
    bus.pc_valid = 1'b0; bus.imem_rsp_data = 32'hAAAA0002; #1;
    vectors++; if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 64'h0, 32'hAAAA0001}) begin miscompares++; $display("FAIL basic_e0: got %b/%h/%h want 1/0/aaaa0001", bus.dec_valid, bus.dec_pc, bus.dec_instr); end
    step();
    bus.imem_rsp_data = 32'hAAAA0003; #1;
    vectors++; if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 64'h4, 32'hAAAA0002}) begin miscompares++; $display("FAIL basic_e1: got %b/%h/%h want 1/4/aaaa0002", bus.dec_valid, bus.dec_pc, bus.dec_instr); end
    step();
    bus.imem_rsp_valid = 1'b0; #1;
    vectors++; if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 64'h8, 32'hAAAA0003}) begin miscompares++; $display("FAIL basic_e2: got %b/%h/%h want 1/8/aaaa0003", bus.dec_valid, bus.dec_pc, bus.dec_instr); end
    step();
    bus.dec_ready = 1'b0; #1;
    vectors++; if (bus.dec_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drained: dec_valid got %b want 0", bus.dec_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL basic_err: got %b want 0", err); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.pc_valid = 1'b1; bus.pc_in = 64'(i * 4); #1;
      vectors++; if (bus.pc_ready !== 1'b1) begin miscompares++; $display("FAIL full_accept%0d: pc_ready got %b want 1", i, bus.pc_ready); end
      step();
    end
    bus.pc_in = 64'h10; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h000000D0; #1;
    vectors++; if (bus.pc_ready !== 1'b0) begin miscompares++; $display("FAIL full_pc_ready: got %b want 0", bus.pc_ready); end
    vectors++; if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_req_valid: got %b want 0", bus.imem_req_valid); end
    step();
    bus.imem_rsp_valid = 1'b0; bus.dec_ready = 1'b1; #1;
    vectors++; if (bus.dec_valid !== 1'b1) begin miscompares++; $display("FAIL full_head_valid: got %b want 1", bus.dec_valid); end
    vectors++; if (bus.pc_ready !== 1'b0) begin miscompares++; $display("FAIL full_pop_same_cycle: pc_ready got %b want 0", bus.pc_ready); end
    step();
    bus.dec_ready = 1'b0; #1;
    vectors++; if (bus.pc_ready !== 1'b1) begin miscompares++; $display("FAIL full_reopen: pc_ready got %b want 1", bus.pc_ready); end
    vectors++; if (bus.dec_valid !== 1'b0) begin miscompares++; $display("FAIL full_next_head: dec_valid got %b want 0", bus.dec_valid); end
    step();
    bus.pc_in = 64'h14; #1;
    vectors++; if (bus.pc_ready !== 1'b0) begin miscompares++; $display("FAIL full_again: pc_ready got %b want 0", bus.pc_ready); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    bus.pc_valid = 1'b1; bus.pc_in = 64'h40; step();
    bus.pc_in = 64'h44; step();
    bus.pc_in = 64'h48; step();
    bus.pc_valid = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h11110001; step();
    bus.imem_rsp_valid = 1'b0; bus.flush = 1'b1; bus.pc_valid = 1'b1; bus.pc_in = 64'h100; #1;
    vectors++; if (bus.pc_ready !== 1'b0) begin miscompares++; $display("FAIL flush_pc_ready: got %b want 0", bus.pc_ready); end
    vectors++; if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL flush_req_valid: got %b want 0", bus.imem_req_valid); end
    vectors++; if (bus.dec_valid !== 1'b1) begin miscompares++; $display("FAIL flush_pre_valid: got %b want 1", bus.dec_valid); end
    step();
    bus.flush = 1'b0; #1;
    vectors++; if (bus.dec_valid !== 1'b0) begin miscompares++; $display("FAIL flush_cleared: dec_valid got %b want 0", bus.dec_valid); end
    vectors++; if (bus.pc_ready !== 1'b1) begin miscompares++; $display("FAIL flush_issue_ok: pc_ready got %b want 1", bus.pc_ready); end
    step();
    bus.pc_valid = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD0001; step();
    bus.imem_rsp_data = 32'hDEAD0002; step();
    bus.imem_rsp_data = 32'hBBBB0003; #1;
    vectors++; if (bus.dec_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped: dec_valid got %b want 0", bus.dec_valid); end
    step();
    bus.imem_rsp_valid = 1'b0; bus.dec_ready = 1'b1; #1;
    vectors++; if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 64'h100, 32'hBBBB0003}) begin miscompares++; $display("FAIL flush_new_pc: got %b/%h/%h want 1/100/bbbb0003", bus.dec_valid, bus.dec_pc, bus.dec_instr); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL flush_err: got %b want 0", err); end
    step();
    idle();
  endtask

  task automatic test_flush_rsp();
    do_reset();
    bus.pc_valid = 1'b1; bus.pc_in = 64'h60; step();
    bus.pc_in = 64'h64; step();
    bus.pc_valid = 1'b0; bus.flush = 1'b1;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hEEEE0001; step();
    bus.flush = 1'b0; bus.imem_rsp_valid = 1'b0; bus.pc_valid = 1'b1; bus.pc_in = 64'h200; step();
    bus.pc_valid = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hEEEE0002; step();
    bus.imem_rsp_data = 32'hCCCC0005; step();
    bus.imem_rsp_valid = 1'b0; #1;
    vectors++; if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 64'h200, 32'hCCCC0005}) begin miscompares++; $display("FAIL flushrsp_entry: got %b/%h/%h want 1/200/cccc0005", bus.dec_valid, bus.dec_pc, bus.dec_instr); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL flushrsp_err: got %b want 0", err); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.pc_valid = 1'b1; bus.pc_in = 64'h18; step();
    bus.pc_in = 64'h1C; step();
    bus.pc_valid = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h000000D1; step();
    bus.pc_valid = 1'b1; bus.pc_in = 64'h20; bus.imem_rsp_data = 32'h000000D2; bus.dec_ready = 1'b1; #1;
    vectors++; if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 64'h18, 32'h000000D1}) begin miscompares++; $display("FAIL b2b_e0: got %b/%h/%h want 1/18/000000d1", bus.dec_valid, bus.dec_pc, bus.dec_instr); end
    vectors++; if (bus.pc_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_pc_ready: got %b want 1", bus.pc_ready); end
    step();
    bus.pc_valid = 1'b0; bus.imem_rsp_data = 32'h000000D3; #1;
    vectors++; if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 64'h1C, 32'h000000D2}) begin miscompares++; $display("FAIL b2b_e1: got %b/%h/%h want 1/1c/000000d2", bus.dec_valid, bus.dec_pc, bus.dec_instr); end
    step();
    bus.imem_rsp_valid = 1'b0; #1;
    vectors++; if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 64'h20, 32'h000000D3}) begin miscompares++; $display("FAIL b2b_e2: got %b/%h/%h want 1/20/000000d3", bus.dec_valid, bus.dec_pc, bus.dec_instr); end
    step();
    bus.dec_ready = 1'b0; #1;
    vectors++; if ((bus.dec_valid !== 1'b0) || (err !== 1'b0)) begin miscompares++; $display("FAIL b2b_drained: dec_valid/err got %b/%b want 0/0", bus.dec_valid, err); end
  endtask

  task automatic test_err();
    do_reset();
    bus.pc_valid = 1'b1; bus.pc_in = 64'h30; step();
    bus.pc_valid = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0E0E0001; step();
    bus.imem_rsp_data = 32'h0BAD0BAD; #1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_before: got %b want 0", err); end
    step();
    bus.imem_rsp_valid = 1'b0; #1;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b want 1", err); end
    vectors++; if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 64'h30, 32'h0E0E0001}) begin miscompares++; $display("FAIL err_fifo: got %b/%h/%h want 1/30/0e0e0001", bus.dec_valid, bus.dec_pc, bus.dec_instr); end
    step();
    bus.dec_ready = 1'b1; step();
    bus.dec_ready = 1'b0; #1;
    vectors++; if ((err !== 1'b1) || (bus.dec_valid !== 1'b0)) begin miscompares++; $display("FAIL err_sticky: err/dec_valid got %b/%b want 1/0", err, bus.dec_valid); end
  endtask

  task automatic test_reset_mid();
    bus.pc_valid = 1'b1; bus.pc_in = 64'h50; step();
    bus.pc_in = 64'h54; step();
    bus.pc_in = 64'h58; step();
    bus.pc_valid = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hF0000001; step();
    bus.imem_rsp_data = 32'hF0000002; step();
    bus.imem_rsp_valid = 1'b0; bus.pc_valid = 1'b1; bus.pc_in = 64'h70; #1;
    vectors++; if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 64'h50, 32'hF0000001}) begin miscompares++; $display("FAIL mid_pre: got %b/%h/%h want 1/50/f0000001", bus.dec_valid, bus.dec_pc, bus.dec_instr); end
    vectors++; if (bus.pc_ready !== 1'b1) begin miscompares++; $display("FAIL mid_pre_ready: got %b want 1", bus.pc_ready); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (bus.dec_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async_dec_valid: got %b want 0", bus.dec_valid); end
    vectors++; if ((bus.pc_ready !== 1'b0) || (bus.imem_req_valid !== 1'b0)) begin miscompares++; $display("FAIL mid_async_ready: pc_ready/req_valid got %b/%b want 0/0", bus.pc_ready, bus.imem_req_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL mid_async_err: got %b want 0", err); end
    bus.pc_valid = 1'b0;
    step();
    reset = 1'b1;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hF0000003; step();
    bus.imem_rsp_valid = 1'b0; #1;
    vectors++; if ((err !== 1'b1) || (bus.dec_valid !== 1'b0)) begin miscompares++; $display("FAIL mid_inflight: err/dec_valid got %b/%b want 1/0", err, bus.dec_valid); end
    bus.pc_valid = 1'b1; bus.pc_in = 64'h70; step();
    bus.pc_valid = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h77777777; step();
    bus.imem_rsp_valid = 1'b0; #1;
    vectors++; if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 64'h70, 32'h77777777}) begin miscompares++; $display("FAIL mid_resume: got %b/%h/%h want 1/70/77777777", bus.dec_valid, bus.dec_pc, bus.dec_instr); end
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_flush_rsp();
    test_back_to_back();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
